// File: rtl/meter_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : meter_scheduler
// Description : Frequency / period / high-time measurement sequencer with
//               input synchroniser, gate timer, tick prescaler and timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module meter_scheduler #(
    parameter int GATE_CYCLES    = 100000000,
    parameter int TICK_DIV       = 100,
    parameter int TIMEOUT_CYCLES = 200000000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic        Continuous,
    input  logic [1:0]  Mode,
    input  logic        SigIn,
    output logic        Busy,
    output logic [15:0] Result,
    output logic        Valid,
    output logic        Overflow,
    output logic        Timeout
);

    localparam int c_gate_w  = $clog2(GATE_CYCLES + 1);
    localparam int c_presc_w = $clog2(TICK_DIV + 1);
    localparam int c_wait_w  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [c_gate_w-1:0]  c_gate_last  = c_gate_w'(GATE_CYCLES - 1);
    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(TICK_DIV - 1);
    localparam logic [c_wait_w-1:0]  c_wait_last  = c_wait_w'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] c_idle = 3'd0;
    localparam logic [2:0] c_gate = 3'd1;
    localparam logic [2:0] c_arm  = 3'd2;
    localparam logic [2:0] c_meas = 3'd3;
    localparam logic [2:0] c_done = 3'd4;

    localparam logic [1:0] c_mode_freq   = 2'b00;
    localparam logic [1:0] c_mode_period = 2'b01;
    localparam logic [1:0] c_mode_high   = 2'b10;

    logic [2:0]           r_state;
    logic [1:0]           r_mode;
    logic                 r_sig_s1;
    logic                 r_sig_s2;
    logic                 r_sig_s3;
    logic                 r_start_d;
    logic [c_gate_w-1:0]  r_gate_cnt;
    logic [c_presc_w-1:0] r_presc;
    logic [c_wait_w-1:0]  r_wait_cnt;
    logic [16:0]          r_edge_cnt;
    logic [16:0]          r_tick_cnt;
    logic                 r_abort;
    logic [15:0]          r_result;
    logic                 r_valid;
    logic                 r_overflow;
    logic                 r_timeout;

    logic [2:0]  w_state_nxt;
    logic        w_launch;
    logic [1:0]  w_next_mode;
    logic [2:0]  w_target;
    logic        w_rise;
    logic        w_fall;
    logic        w_stop_edge;
    logic        w_start_rise;
    logic        w_wait_expired;
    logic [16:0] w_count;

    assign w_rise         = r_sig_s2 & ~r_sig_s3;
    assign w_fall         = ~r_sig_s2 & r_sig_s3;
    assign w_start_rise   = Start & ~r_start_d;
    // Reserved mode 11 is folded onto frequency at latch time
    assign w_next_mode    = (Mode == 2'b11) ? c_mode_freq : Mode;
    assign w_target       = (w_next_mode == c_mode_freq) ? c_gate : c_arm;
    assign w_stop_edge    = (r_mode == c_mode_high) ? w_fall : w_rise;
    assign w_wait_expired = (r_wait_cnt == c_wait_last);
    assign w_count        = (r_mode == c_mode_freq) ? r_edge_cnt : r_tick_cnt;

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        case (r_state)
            c_idle: begin
                if (w_start_rise) begin
                    w_launch    = 1'b1;
                    w_state_nxt = w_target;
                end
            end
            c_gate: begin
                if (r_gate_cnt == c_gate_last) w_state_nxt = c_done;
            end
            c_arm: begin
                if (w_rise || w_wait_expired) w_state_nxt = w_rise ? c_meas : c_done;
            end
            c_meas: begin
                if (w_stop_edge || w_wait_expired) w_state_nxt = c_done;
            end
            c_done: begin
                if (Continuous) begin
                    w_launch    = 1'b1;
                    w_state_nxt = w_target;
                end else begin
                    w_state_nxt = c_idle;
                end
            end
            default: w_state_nxt = c_idle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state    <= c_idle;
            r_mode     <= c_mode_freq;
            r_sig_s1   <= 1'b0;
            r_sig_s2   <= 1'b0;
            r_sig_s3   <= 1'b0;
            r_start_d  <= 1'b0;
            r_gate_cnt <= '0;
            r_presc    <= '0;
            r_wait_cnt <= '0;
            r_edge_cnt <= '0;
            r_tick_cnt <= '0;
            r_abort    <= 1'b0;
            r_result   <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sig_s1  <= SigIn;
            r_sig_s2  <= r_sig_s1;
            r_sig_s3  <= r_sig_s2;
            r_start_d <= Start;
            r_valid   <= 1'b0;

            case (r_state)
                c_gate: begin
                    r_gate_cnt <= r_gate_cnt + 1'b1;
                    if (w_rise && !r_edge_cnt[16]) r_edge_cnt <= r_edge_cnt + 17'd1;
                end
                c_arm: begin
                    if (w_rise) begin
                        r_tick_cnt <= '0;
                        r_presc    <= '0;
                        r_wait_cnt <= '0;
                    end else if (w_wait_expired) begin
                        r_abort <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                c_meas: begin
                    // Tick counter saturates at 2^16 so Overflow stays sticky
                    if (r_presc == c_presc_last) begin
                        r_presc <= '0;
                        if (!r_tick_cnt[16]) r_tick_cnt <= r_tick_cnt + 17'd1;
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                    if (w_stop_edge) begin
                        r_wait_cnt <= '0;
                    end else if (w_wait_expired) begin
                        r_abort <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                c_done: begin
                    r_valid <= 1'b1;
                    if (r_abort) begin
                        r_result   <= '0;
                        r_overflow <= 1'b0;
                        r_timeout  <= 1'b1;
                    end else begin
                        r_result   <= w_count[16] ? 16'hFFFF : w_count[15:0];
                        r_overflow <= w_count[16];
                        r_timeout  <= 1'b0;
                    end
                end
                default: ;
            endcase

            if (w_launch) begin
                r_mode     <= w_next_mode;
                r_gate_cnt <= '0;
                r_edge_cnt <= '0;
                r_wait_cnt <= '0;
                r_abort    <= 1'b0;
            end
        end
    end

    assign Busy     = (r_state != c_idle);
    assign Result   = r_result;
    assign Valid    = r_valid;
    assign Overflow = r_overflow;
    assign Timeout  = r_timeout;

endmodule
`default_nettype wire
